// File: rtl/compare_loader.sv
// rtl/compare_loader.sv - serial 3-wire compare value loader for the seconds counter
//
// Purpose:
//   Receives a WIDTH-bit compare value, MSB first, over an asynchronous
//   3-wire link (serial clock, data, active-low frame select). All three
//   pad signals are synchronised into the clk domain. A frame of exactly
//   WIDTH bits is committed to compare_out, with a single-cycle
//   update_compare pulse. A frame with the wrong bit count, or one that
//   stalls for TIMEOUT cycles, is rejected and raises frame_err.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   ser_clk_in     serial clock from pad (data sampled on its rising edge)
//   ser_data_in    serial data from pad
//   ser_cs_n_in    frame select from pad, active low
//   compare_out    committed compare value
//   update_compare one-cycle pulse on the first cycle of a new compare_out
//   frame_err      sticky error flag, cleared at the next frame start
//   busy           high while a frame is in progress or being aborted

`timescale 1ns/1ps

module compare_loader #(
  parameter int unsigned     WIDTH       = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = 'h100,
  parameter int unsigned     TIMEOUT     = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ser_clk_in,
  input  logic             ser_data_in,
  input  logic             ser_cs_n_in,
  output logic [WIDTH-1:0] compare_out,
  output logic             update_compare,
  output logic             frame_err,
  output logic             busy
);

  // Bit counter must hold WIDTH+1 (the "too many bits" saturation value).
  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Pad synchronisers. Reset to 1 so that an idle-high link produces no
  // spurious edges when reset is released.
  // ---------------------------------------------------------------------
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic cs_meta_q,   cs_sync_q,   cs_prev_q;
  logic data_meta_q, data_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_meta_q <= 1'b1;
      sclk_sync_q <= 1'b1;
      sclk_prev_q <= 1'b1;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      sclk_meta_q <= ser_clk_in;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      cs_meta_q   <= ser_cs_n_in;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      data_meta_q <= ser_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  logic sclk_rise, cs_fall, cs_rise;

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign cs_fall   = ~cs_sync_q & cs_prev_q;
  assign cs_rise   = cs_sync_q & ~cs_prev_q;

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t           state_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]    to_cnt_q;
  logic [WIDTH-1:0] compare_q;
  logic             update_q;
  logic             err_q;
  logic             busy_q;

  assign shift_d   = {shift_q[WIDTH-2:0], data_sync_q};
  // Saturate one past WIDTH so an over-long frame can never wrap back to a
  // count that looks valid.
  assign bit_cnt_d = (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      compare_q <= RESET_VALUE;
      update_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      update_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q   <= ST_SHIFT;
            busy_q    <= 1'b1;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
          end
        end

        ST_SHIFT: begin
          // End of frame wins over a coincident serial clock edge.
          if (cs_rise) begin
            if (bit_cnt_q == CNT_FULL) begin
              compare_q <= shift_q;
              update_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (sclk_rise) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= '0;
          end else if (to_cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_ABORT;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        ST_ABORT: begin
          // Stay here until the master closes the frame; a fresh frame needs
          // a new falling edge of cs_n seen from IDLE.
          if (cs_rise) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign compare_out    = compare_q;
  assign update_compare = update_q;
  assign frame_err      = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_compare_loader.sv
// tb/tb_compare_loader.sv - self-checking bench for compare_loader

`timescale 1ns/1ps

module tb_compare_loader;

  localparam int W    = 24;
  localparam int TOUT = 4096;
  localparam int PH   = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ser_clk;
  logic          ser_data;
  logic          ser_cs_n;
  logic [W-1:0]  compare_out;
  logic          update_compare;
  logic          frame_err;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int dbl_cnt = 0;
  logic upd_prev = 1'b0;

  always #5 clk = ~clk;

  compare_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ser_clk_in     (ser_clk),
    .ser_data_in    (ser_data),
    .ser_cs_n_in    (ser_cs_n),
    .compare_out    (compare_out),
    .update_compare (update_compare),
    .frame_err      (frame_err),
    .busy           (busy)
  );

  // Pulse monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (update_compare) pulse_cnt++;
    if (update_compare && upd_prev) dbl_cnt++;
    upd_prev = update_compare;
  end

  typedef struct {
    logic [W-1:0] data;
    int           nbits;
    logic [W-1:0] exp_cmp;
    int           exp_pulses;
    logic         exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends nbits MSB first; bits beyond W are ones. hold=0 leaves cs_n low,
  // otherwise cs_n is raised and held for hold cycles.
  task automatic send_frame(input logic [W-1:0] data, input int nbits, input int hold);
    ser_cs_n = 1'b0;
    wait_cyc(PH);
    for (int i = 0; i < nbits; i++) begin
      ser_clk = 1'b0;
      if (i < W) ser_data = data[W-1-i];
      else       ser_data = 1'b1;
      wait_cyc(PH);
      ser_clk = 1'b1;
      wait_cyc(PH);
    end
    ser_clk = 1'b0;
    wait_cyc(PH);
    if (hold > 0) begin
      ser_cs_n = 1'b1;
      wait_cyc(hold);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int lat;
    logic [W-1:0] cmp_at_pulse;
    logic [W-1:0] cmp_hold;

    vecs[0] = '{24'h0003E8, 23, 24'h0003E8, 0, 1'b1};
    vecs[1] = '{24'h0003E8, 25, 24'h0003E8, 0, 1'b1};
    vecs[2] = '{24'hFFFFFF, 24, 24'hFFFFFF, 1, 1'b0};
    vecs[3] = '{24'h000000, 24, 24'h000000, 1, 1'b0};
    vecs[4] = '{24'hA5A5A5, 24, 24'hA5A5A5, 1, 1'b0};
    vecs[5] = '{24'h5A5A5A,  0, 24'hA5A5A5, 0, 1'b1};
    vecs[6] = '{24'h800001, 24, 24'h800001, 1, 1'b0};
    vecs[7] = '{24'h0003E8, 24, 24'h0003E8, 1, 1'b0};

    reset_n  = 1'b0;
    ser_clk  = 1'b0;
    ser_data = 1'b0;
    ser_cs_n = 1'b1;
    @(negedge clk);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(20);
    check("reset compare_out", 32'(compare_out), 32'h000100);
    check("reset update", 32'(update_compare), 0);
    check("reset frame_err", 32'(frame_err), 0);
    check("reset busy", 32'(busy), 0);

    // First valid frame with latency measurement.
    p0 = pulse_cnt;
    send_frame(24'h0003E8, 24, 0);
    ser_cs_n = 1'b1;
    lat = 0;
    cmp_at_pulse = '0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (update_compare && lat == 0) begin
        lat = k;
        cmp_at_pulse = compare_out;
      end
    end
    wait_cyc(10);
    check("commit latency", 32'(lat), 3);
    check("compare at pulse", 32'(cmp_at_pulse), 32'h0003E8);
    check("first pulses", 32'(pulse_cnt - p0), 1);
    check("first frame_err", 32'(frame_err), 0);

    foreach (vecs[i]) begin
      p0 = pulse_cnt;
      send_frame(vecs[i].data, vecs[i].nbits, 12);
      check($sformatf("vec%0d compare", i), 32'(compare_out), 32'(vecs[i].exp_cmp));
      check($sformatf("vec%0d pulses", i), 32'(pulse_cnt - p0), 32'(vecs[i].exp_pulses));
      check($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d busy", i), 32'(busy), 0);
    end

    // Timeout: 5 bits then stall.
    cmp_hold = compare_out;
    p0 = pulse_cnt;
    send_frame(24'hFFFFFF, 5, 0);
    wait_cyc(TOUT + 20);
    check("timeout frame_err", 32'(frame_err), 1);
    check("timeout busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      ser_data = 1'b1;
      ser_clk  = 1'b1;
      wait_cyc(PH);
      ser_clk  = 1'b0;
      wait_cyc(PH);
    end
    check("abort busy after sclk", 32'(busy), 1);
    check("abort frame_err after sclk", 32'(frame_err), 1);
    ser_cs_n = 1'b1;
    wait_cyc(10);
    check("abort busy released", 32'(busy), 0);
    check("abort compare", 32'(compare_out), 32'(cmp_hold));
    check("abort pulses", 32'(pulse_cnt - p0), 0);

    // Back-to-back frames with cs_n high for a single cycle.
    p0 = pulse_cnt;
    send_frame(24'hABCDEF, 24, 1);
    send_frame(24'h000001, 24, 12);
    check("b2b pulses", 32'(pulse_cnt - p0), 2);
    check("b2b compare", 32'(compare_out), 32'h000001);
    check("b2b frame_err", 32'(frame_err), 0);

    // Reset in the middle of a frame.
    p0 = pulse_cnt;
    send_frame(24'hFEDCBA, 12, 0);
    reset_n = 1'b0;
    wait_cyc(1);
    check("midreset compare", 32'(compare_out), 32'h000100);
    check("midreset busy", 32'(busy), 0);
    check("midreset update", 32'(update_compare), 0);
    ser_cs_n = 1'b1;
    ser_clk  = 1'b0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(10);
    check("midreset pulses", 32'(pulse_cnt - p0), 0);
    check("midreset busy after", 32'(busy), 0);
    p0 = pulse_cnt;
    send_frame(24'h123456, 24, 12);
    check("post reset compare", 32'(compare_out), 32'h123456);
    check("post reset pulses", 32'(pulse_cnt - p0), 1);
    check("post reset frame_err", 32'(frame_err), 0);

    check("double pulses", 32'(dbl_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
